// File: rtl/spi_led_frame_rx.sv
// Receive side of the LED-strip serial link: oversamples a mode-0 SPI pair,
// assembles bytes and parses the APA102-style start / LED / end frame stream.
module spi_led_frame_rx #(
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int LED_INDEX_WIDTH = 8
) (
    input  logic                       spi_clk,
    input  logic                       spi_reset_n,
    input  logic                       spi_input_clock,
    input  logic                       spi_input_data,
    output logic [7:0]                 rx_byte,
    output logic                       rx_byte_valid,
    output logic                       rx_busy,
    output logic                       led_valid,
    output logic [4:0]                 led_brightness,
    output logic [7:0]                 led_blue,
    output logic [7:0]                 led_green,
    output logic [7:0]                 led_red,
    output logic [LED_INDEX_WIDTH-1:0] led_index,
    output logic                       frame_done,
    output logic                       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LED_INDEX_WIDTH-1:0] INDEX_MAX = '1;

    typedef enum logic {
        STATE_HUNT = 1'b0,
        STATE_LED  = 1'b1
    } state_t;

    logic clk_sync1, clk_sync2, clk_sync3;
    logic data_sync1, data_sync2;
    logic serial_rise;

    logic [6:0] shift_reg;
    logic [2:0] bit_count;

    logic [TW-1:0] timeout_count;
    logic          timer_active;
    logic          timeout_hit;

    state_t                     state, state_next;
    logic [2:0]                 zero_count, zero_count_next;
    logic [1:0]                 quartet_count, quartet_count_next;
    logic [7:0]                 header_byte, header_next;
    logic [7:0]                 blue_byte, blue_next;
    logic [7:0]                 green_byte, green_next;
    logic [LED_INDEX_WIDTH-1:0] led_count, led_count_next;
    logic                       led_load, frame_done_next, frame_error_next;
    logic                       take_header;

    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) begin
            clk_sync1  <= 1'b0;
            clk_sync2  <= 1'b0;
            clk_sync3  <= 1'b0;
            data_sync1 <= 1'b0;
            data_sync2 <= 1'b0;
        end else begin
            clk_sync1  <= spi_input_clock;
            clk_sync2  <= clk_sync1;
            clk_sync3  <= clk_sync2;
            data_sync1 <= spi_input_data;
            data_sync2 <= data_sync1;
        end
    end

    assign serial_rise = clk_sync2 & ~clk_sync3;
    assign rx_busy     = (bit_count != 3'd0);

    // A serial edge takes priority over an expiring timeout on the same cycle.
    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) begin
            shift_reg     <= '0;
            bit_count     <= '0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
        end else begin
            rx_byte_valid <= 1'b0;
            if (serial_rise) begin
                shift_reg <= {shift_reg[5:0], data_sync2};
                bit_count <= bit_count + 3'd1;
                if (bit_count == 3'd7) begin
                    rx_byte       <= {shift_reg, data_sync2};
                    rx_byte_valid <= 1'b1;
                end
            end else if (timeout_hit) begin
                bit_count <= '0;
            end
        end
    end

    assign timer_active = (bit_count != 3'd0) ||
                          ((state == STATE_LED) && (quartet_count != 2'd0));
    assign timeout_hit  = timer_active && !serial_rise && (timeout_count == TIMEOUT_LAST);

    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) begin
            timeout_count <= '0;
        end else if (serial_rise || !timer_active || timeout_hit) begin
            timeout_count <= '0;
        end else begin
            timeout_count <= timeout_count + 1'b1;
        end
    end

    always_comb begin
        state_next         = state;
        zero_count_next    = zero_count;
        quartet_count_next = quartet_count;
        header_next        = header_byte;
        blue_next          = blue_byte;
        green_next         = green_byte;
        led_count_next     = led_count;
        led_load           = 1'b0;
        frame_done_next    = 1'b0;
        frame_error_next   = 1'b0;
        take_header        = 1'b0;

        if (timeout_hit) begin
            state_next         = STATE_HUNT;
            zero_count_next    = '0;
            quartet_count_next = '0;
            frame_error_next   = 1'b1;
        end else if (rx_byte_valid) begin
            case (state)
                STATE_HUNT: begin
                    if (rx_byte == 8'h00) begin
                        if (zero_count != 3'd4) begin
                            zero_count_next = zero_count + 3'd1;
                        end
                        if (zero_count >= 3'd3) begin
                            led_count_next = '0;
                        end
                    end else if (zero_count == 3'd4) begin
                        take_header = 1'b1;
                    end else begin
                        zero_count_next = '0;
                    end
                end
                STATE_LED: begin
                    case (quartet_count)
                        2'd0: begin
                            // A zero where a header belongs opens a new start frame.
                            if (rx_byte == 8'h00) begin
                                state_next      = STATE_HUNT;
                                zero_count_next = 3'd1;
                            end else begin
                                take_header = 1'b1;
                            end
                        end
                        2'd1: begin
                            blue_next          = rx_byte;
                            quartet_count_next = 2'd2;
                        end
                        2'd2: begin
                            green_next         = rx_byte;
                            quartet_count_next = 2'd3;
                        end
                        default: begin
                            quartet_count_next = 2'd0;
                            if ((header_byte == 8'hFF) && (blue_byte == 8'hFF) &&
                                (green_byte == 8'hFF) && (rx_byte == 8'hFF)) begin
                                frame_done_next = 1'b1;
                                state_next      = STATE_HUNT;
                                zero_count_next = '0;
                            end else begin
                                led_load = 1'b1;
                                if (led_count != INDEX_MAX) begin
                                    led_count_next = led_count + 1'b1;
                                end
                            end
                        end
                    endcase
                end
                default: state_next = STATE_HUNT;
            endcase

            if (take_header) begin
                if (rx_byte[7:5] == 3'b111) begin
                    state_next         = STATE_LED;
                    header_next        = rx_byte;
                    quartet_count_next = 2'd1;
                end else begin
                    frame_error_next = 1'b1;
                    state_next       = STATE_HUNT;
                    zero_count_next  = '0;
                end
            end
        end
    end

    // The red byte is taken straight from rx_byte as the quartet completes.
    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) begin
            state          <= STATE_HUNT;
            zero_count     <= '0;
            quartet_count  <= '0;
            header_byte    <= '0;
            blue_byte      <= '0;
            green_byte     <= '0;
            led_count      <= '0;
            led_valid      <= 1'b0;
            frame_done     <= 1'b0;
            frame_error    <= 1'b0;
            led_brightness <= '0;
            led_blue       <= '0;
            led_green      <= '0;
            led_red        <= '0;
            led_index      <= '0;
        end else begin
            state         <= state_next;
            zero_count    <= zero_count_next;
            quartet_count <= quartet_count_next;
            header_byte   <= header_next;
            blue_byte     <= blue_next;
            green_byte    <= green_next;
            led_count     <= led_count_next;
            led_valid     <= led_load;
            frame_done    <= frame_done_next;
            frame_error   <= frame_error_next;
            if (led_load) begin
                led_brightness <= header_byte[4:0];
                led_blue       <= blue_byte;
                led_green      <= green_byte;
                led_red        <= rx_byte;
                led_index      <= led_count;
            end
        end
    end

endmodule
